// File: rtl/m68k_bus_pkg.sv
// Shared types and default region map for the 68000 bus-cycle controller.
// The default table covers EEPROM, RAM, an externally acknowledged IO window and one disabled slot.
package m68k_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_EXTWAIT,
        ST_BOOTWAIT,
        ST_ACK,
        ST_BERR
    } bus_state_e;

    localparam int DEF_NUM_REGIONS = 4;

    // Region bounds are in 8 KiB units (A[23:13]); NONE has base > limit so it never hits.
    localparam logic [10:0] EEPROM_BASE  = 11'h000;
    localparam logic [10:0] EEPROM_LIMIT = 11'h001;
    localparam logic [10:0] RAM_BASE     = 11'h002;
    localparam logic [10:0] RAM_LIMIT    = 11'h007;
    localparam logic [10:0] IO_BASE      = 11'h008;
    localparam logic [10:0] IO_LIMIT     = 11'h00F;
    localparam logic [10:0] NONE_BASE    = 11'h7FF;
    localparam logic [10:0] NONE_LIMIT   = 11'h000;

    localparam logic [3:0] EEPROM_WAIT = 4'd4;
    localparam logic [3:0] RAM_WAIT    = 4'd0;
    localparam logic [3:0] IO_WAIT     = 4'd0;
    localparam logic [3:0] NONE_WAIT   = 4'd0;

    localparam logic [DEF_NUM_REGIONS*11-1:0] DEF_REGION_BASE =
        {NONE_BASE, IO_BASE, RAM_BASE, EEPROM_BASE};
    localparam logic [DEF_NUM_REGIONS*11-1:0] DEF_REGION_LIMIT =
        {NONE_LIMIT, IO_LIMIT, RAM_LIMIT, EEPROM_LIMIT};
    localparam logic [DEF_NUM_REGIONS*4-1:0] DEF_REGION_WAIT =
        {NONE_WAIT, IO_WAIT, RAM_WAIT, EEPROM_WAIT};
    localparam logic [DEF_NUM_REGIONS-1:0] DEF_REGION_EXT = 4'b0100;

    localparam int DEF_TIMEOUT = 64;

    function automatic int tcnt_width(input int timeout);
        return (timeout <= 2) ? 1 : $clog2(timeout);
    endfunction

    localparam int TCNT_W = tcnt_width(DEF_TIMEOUT);

endpackage

// File: rtl/m68k_bus_ctrl_if.sv
// CPU-side bus signals of the 68000 bus-cycle controller, grouped for the controller and the CPU model.
interface m68k_bus_ctrl_if #(
    parameter int NUM_REGIONS = 4
);
    // Handshake: the CPU holds as_n low with addr/strobes stable for the whole cycle; the
    // controller answers with exactly one of dtack_n or berr_n low and keeps it low until
    // as_n returns high. Raising as_n before any answer aborts the cycle with no answer.
    logic                   as_n;
    logic                   uds_n;
    logic                   lds_n;
    logic                   rw;
    logic [10:0]            addr;
    logic                   boot;
    logic                   dtack_trig;
    logic                   ext_dtack_n;
    logic                   dtack_n;
    logic                   berr_n;
    logic [NUM_REGIONS-1:0] cs;
    logic [NUM_REGIONS-1:0] ce_n;
    logic                   oe_n;

    modport master (
        output as_n, uds_n, lds_n, rw, addr, boot, dtack_trig, ext_dtack_n,
        input  dtack_n, berr_n, cs, ce_n, oe_n
    );

    modport slave (
        input  as_n, uds_n, lds_n, rw, addr, boot, dtack_trig, ext_dtack_n,
        output dtack_n, berr_n, cs, ce_n, oe_n
    );
endinterface

// File: rtl/m68k_bus_ctrl_sync2.sv
// Two-flop synchronizer for a vector of independent asynchronous inputs.
// Both stages reset to RST_VAL so the outputs start at the inputs' idle level.
module m68k_sync2 #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta_q, meta_d;
    logic [W-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;
endmodule

// File: rtl/m68k_bus_ctrl.sv
// 68000 bus-cycle controller: region decode, per-region wait states or external/boot DTACK,
// bus error on unmapped or hung cycles.
module m68k_bus_ctrl
    import m68k_bus_pkg::*;
#(
    parameter int                       NUM_REGIONS  = DEF_NUM_REGIONS,
    parameter logic [NUM_REGIONS*11-1:0] REGION_BASE  = DEF_REGION_BASE,
    parameter logic [NUM_REGIONS*11-1:0] REGION_LIMIT = DEF_REGION_LIMIT,
    parameter logic [NUM_REGIONS*4-1:0]  REGION_WAIT  = DEF_REGION_WAIT,
    parameter logic [NUM_REGIONS-1:0]    REGION_EXT   = DEF_REGION_EXT,
    parameter int                       TIMEOUT      = DEF_TIMEOUT
) (
    input  logic             clk16,
    input  logic             reset,
    m68k_bus_ctrl_if.slave   bus,
    output bus_state_e       state_dbg
);
    localparam int                    TCNT_BITS = tcnt_width(TIMEOUT);
    localparam logic [TCNT_BITS-1:0] TCNT_LAST = TCNT_BITS'(TIMEOUT - 1);

    logic [2:0] sync_out;
    logic       as_s;
    logic       trig_s;
    logic       ext_s;
    logic       trig_pe;
    logic       trig_prev_q, trig_prev_d;

    m68k_sync2 #(
        .W       (3),
        .RST_VAL (3'b111)
    ) u_sync (
        .clk (clk16),
        .rst (reset),
        .d   ({bus.ext_dtack_n, bus.dtack_trig, bus.as_n}),
        .q   (sync_out)
    );

    assign {ext_s, trig_s, as_s} = sync_out;
    assign trig_pe               = trig_s & ~trig_prev_q;
    assign trig_prev_d           = trig_s;

    logic [NUM_REGIONS-1:0] hit;

    for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_region
        assign hit[g] = (bus.addr >= REGION_BASE[g*11 +: 11]) &&
                        (bus.addr <= REGION_LIMIT[g*11 +: 11]);
    end

    logic [NUM_REGIONS-1:0] sel_oh;
    logic [3:0]             sel_wait;
    logic                   sel_ext;
    logic                   any_hit;

    // Walk from the top index down so the lowest hitting region is the one left standing.
    always_comb begin
        sel_oh   = '0;
        sel_wait = '0;
        sel_ext  = 1'b0;
        for (int r = NUM_REGIONS - 1; r >= 0; r--) begin
            if (hit[r]) begin
                sel_oh    = '0;
                sel_oh[r] = 1'b1;
                sel_wait  = REGION_WAIT[r*4 +: 4];
                sel_ext   = REGION_EXT[r];
            end
        end
        any_hit = |hit;
    end

    bus_state_e             state_q, state_d;
    logic [3:0]             wcnt_q, wcnt_d;
    logic [TCNT_BITS-1:0]   tcnt_q, tcnt_d;
    logic [NUM_REGIONS-1:0] cs_q, cs_d;
    logic                   dtack_n_q, dtack_n_d;
    logic                   berr_n_q, berr_n_d;
    logic                   timeout;

    assign timeout = (tcnt_q == TCNT_LAST);

    // A CPU abort (as_s high) wins over everything, then timeout, then the acknowledge.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        tcnt_d  = tcnt_q;
        case (state_q)
            ST_IDLE: begin
                tcnt_d = '0;
                if (!as_s) begin
                    if (!any_hit) begin
                        state_d = ST_BERR;
                    end else if (sel_oh[0] && bus.boot) begin
                        state_d = ST_BOOTWAIT;
                    end else if (sel_ext) begin
                        state_d = ST_EXTWAIT;
                    end else begin
                        state_d = ST_WAIT;
                        wcnt_d  = sel_wait;
                    end
                end
            end
            ST_WAIT: begin
                tcnt_d = tcnt_q + TCNT_BITS'(1);
                if (as_s) begin
                    state_d = ST_IDLE;
                end else if (timeout) begin
                    state_d = ST_BERR;
                end else if (wcnt_q == 4'd0) begin
                    state_d = ST_ACK;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            ST_EXTWAIT: begin
                tcnt_d = tcnt_q + TCNT_BITS'(1);
                if (as_s) begin
                    state_d = ST_IDLE;
                end else if (timeout) begin
                    state_d = ST_BERR;
                end else if (!ext_s) begin
                    state_d = ST_ACK;
                end
            end
            ST_BOOTWAIT: begin
                tcnt_d = tcnt_q + TCNT_BITS'(1);
                if (as_s) begin
                    state_d = ST_IDLE;
                end else if (timeout) begin
                    state_d = ST_BERR;
                end else if (trig_pe) begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK, ST_BERR: begin
                tcnt_d = '0;
                if (as_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tcnt_d  = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they change on the same edge as the FSM.
    always_comb begin
        dtack_n_d = (state_d != ST_ACK);
        berr_n_d  = (state_d != ST_BERR);
        cs_d      = '0;
        case (state_d)
            ST_WAIT, ST_EXTWAIT, ST_BOOTWAIT, ST_ACK:
                cs_d = (state_q == ST_IDLE) ? sel_oh : cs_q;
            default:
                cs_d = '0;
        endcase
    end

    always_ff @(posedge clk16) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            wcnt_q      <= '0;
            tcnt_q      <= '0;
            cs_q        <= '0;
            dtack_n_q   <= 1'b1;
            berr_n_q    <= 1'b1;
            trig_prev_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            tcnt_q      <= tcnt_d;
            cs_q        <= cs_d;
            dtack_n_q   <= dtack_n_d;
            berr_n_q    <= berr_n_d;
            trig_prev_q <= trig_prev_d;
        end
    end

    assign bus.dtack_n = dtack_n_q;
    assign bus.berr_n  = berr_n_q;
    assign bus.cs      = cs_q;
    assign bus.ce_n    = ~cs_q | {NUM_REGIONS{bus.uds_n & bus.lds_n}};
    assign bus.oe_n    = bus.boot ? 1'b1 : ((|cs_q) ? ~bus.rw : 1'b1);
    assign state_dbg   = state_q;
endmodule

// File: tb/tb_m68k_bus_ctrl.sv
// Directed bench for m68k_bus_ctrl: a per-transaction timing model predicts dtack_n/berr_n/cs
// windows in clock edges and every cycle's outputs are compared against it.
module tb_m68k_bus_ctrl;
  import m68k_bus_pkg::*;

  localparam int TIMEOUT = 64;
  localparam int BIG     = 1 << 30;

  logic clk16 = 1'b0;
  logic reset = 1'b1;
  always #5 clk16 = ~clk16;

  m68k_bus_ctrl_if #(.NUM_REGIONS(4)) bus ();
  bus_state_e state_dbg;

  m68k_bus_ctrl #(
    .NUM_REGIONS (4),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk16     (clk16),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // Memory map as documented: EEPROM 000-001 (4 waits), RAM 002-007, IO 008-00F (ext), slot 3 off.
  int base_t  [4] = '{0, 2, 8, 'h7FF};
  int limit_t [4] = '{1, 7, 'hF, 0};
  int wait_t  [4] = '{4, 0, 0, 0};
  int ext_t   [4] = '{0, 0, 1, 0};

  typedef struct {
    int         s;
    int         rel;
    int         ack_e;
    int         berr_e;
    int         rst_e;
    logic [3:0] oh;
  } txn_t;

  txn_t txns [64];
  int   n_txn    = 0;
  int   edge_cnt = 0;
  int   n_tests  = 0;
  int   n_fail   = 0;
  logic [7:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", name, edge_cnt, act, exp);
    end
  endtask

  // Output state after edge n: each transaction contributes its select/ack/error window.
  function automatic void model_at(input int n, output logic [3:0] cs_e,
                                   output logic dt_e, output logic be_e);
    int b;
    cs_e = 4'b0;
    dt_e = 1'b1;
    be_e = 1'b1;
    for (int k = 0; k < n_txn; k++) begin
      b = txns[k].rel + 2;
      if (txns[k].rst_e < b) b = txns[k].rst_e;
      if (n >= txns[k].s + 2 && n < b && n < txns[k].berr_e) cs_e = cs_e | txns[k].oh;
      if (n >= txns[k].ack_e && n < b) dt_e = 1'b0;
      if (n >= txns[k].berr_e && n < b) be_e = 1'b0;
    end
  endfunction

  task automatic check_cycle();
    logic [3:0] cs_e;
    logic       dt_e, be_e, oe_e;
    logic [3:0] ce_e;
    model_at(edge_cnt, cs_e, dt_e, be_e);
    ce_e = ~cs_e | {4{bus.uds_n & bus.lds_n}};
    oe_e = bus.boot ? 1'b1 : ((cs_e != 4'b0) ? ~bus.rw : 1'b1);
    chk("dtack_n", 32'(bus.dtack_n), 32'(dt_e));
    chk("berr_n",  32'(bus.berr_n),  32'(be_e));
    chk("cs",      32'(bus.cs),      32'(cs_e));
    chk("ce_n",    32'(bus.ce_n),    32'(ce_e));
    chk("oe_n",    32'(bus.oe_n),    32'(oe_e));
  endtask

  initial begin
    forever begin
      @(posedge clk16);
      edge_cnt++;
      #2;
      check_cycle();
    end
  end

  task automatic check_idle_literal(input string tag);
    chk({tag, "_dtack_n"}, 32'(bus.dtack_n), 32'd1);
    chk({tag, "_berr_n"},  32'(bus.berr_n),  32'd1);
    chk({tag, "_cs"},      32'(bus.cs),      32'd0);
    chk({tag, "_ce_n"},    32'(bus.ce_n),    32'hF);
    chk({tag, "_oe_n"},    32'(bus.oe_n),    32'd1);
    chk({tag, "_state"},   32'(state_dbg),   32'(ST_IDLE));
  endtask

  // Called at a falling edge; as_n goes low here so the next rising edge is the cycle's edge 1.
  task automatic bus_cycle(input logic [10:0] a, input logic u, input logic l, input logic r,
                           input logic b, input int ext_at, input int trig_at, input int hold,
                           input int rst_at, input int gap, input bit pin);
    int k, s, reg_i, t, tmo, cand, lat;
    bit done_rst;
    k = n_txn;
    n_txn++;
    s = edge_cnt + 1;
    txns[k].s = s;
    txns[k].rel = BIG;
    txns[k].ack_e = BIG;
    txns[k].berr_e = BIG;
    txns[k].rst_e = BIG;
    txns[k].oh = 4'b0;
    reg_i = -1;
    for (int i = 3; i >= 0; i--)
      if (int'(a) >= base_t[i] && int'(a) <= limit_t[i]) reg_i = i;
    if (reg_i < 0) begin
      txns[k].berr_e = s + 2;
    end else begin
      txns[k].oh = 4'(1 << reg_i);
      t = -2;
      if (reg_i == 0 && b) t = trig_at;
      else if (ext_t[reg_i] != 0) t = ext_at;
      else txns[k].ack_e = s + 3 + wait_t[reg_i];
      if (t != -2) begin
        tmo = s + 2 + TIMEOUT;
        cand = s + t + 2;
        if (cand < s + 3) cand = s + 3;
        if (t >= 0 && cand < tmo) txns[k].ack_e = cand;
        else txns[k].berr_e = tmo;
      end
    end
    bus.addr = a;
    bus.uds_n = u;
    bus.lds_n = l;
    bus.rw = r;
    bus.boot = b;
    bus.as_n = 1'b0;
    done_rst = 1'b0;
    for (int i = 0; i < hold; i++) begin
      if (i == ext_at) bus.ext_dtack_n = 1'b0;
      if (i == trig_at) bus.dtack_trig = 1'b1;
      if (i == rst_at) begin
        reset = 1'b1;
        bus.as_n = 1'b1;
        txns[k].rst_e = edge_cnt + 1;
        @(negedge clk16);
        reset = 1'b0;
        check_idle_literal("midrst");
        done_rst = 1'b1;
        break;
      end
      @(negedge clk16);
    end
    if (!done_rst) txns[k].rel = edge_cnt + 1;
    bus.as_n = 1'b1;
    bus.uds_n = 1'b1;
    bus.lds_n = 1'b1;
    bus.ext_dtack_n = 1'b1;
    bus.dtack_trig = 1'b0;
    if (pin) begin
      lat = (txns[k].ack_e < BIG) ? txns[k].ack_e - s : txns[k].berr_e - s;
      chk("latency", 32'(lat), 32'(exp_q.pop_front()));
    end
    repeat (gap) @(negedge clk16);
    bus.boot = 1'b0;
  endtask

  initial begin
    int pins [16] = '{3, 7, 2, 66, 12, 66, 7, 3, 7, 3, 3, 2, 2, 3, 7, 3};
    foreach (pins[i]) exp_q.push_back(8'(pins[i]));
    bus.as_n = 1'b1;
    bus.uds_n = 1'b1;
    bus.lds_n = 1'b1;
    bus.rw = 1'b1;
    bus.addr = 11'h000;
    bus.boot = 1'b0;
    bus.dtack_trig = 1'b0;
    bus.ext_dtack_n = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk16);
    check_idle_literal("reset");
    reset = 1'b0;
    @(negedge clk16);

    //        addr     u     l     rw    boot  ext  trig hold rst gap pin
    bus_cycle(11'h003, 1'b0, 1'b0, 1'b1, 1'b0, -1,  -1,  8,  -1, 6, 1'b1);
    bus_cycle(11'h000, 1'b0, 1'b1, 1'b1, 1'b0, -1,  -1,  12, -1, 6, 1'b1);
    bus_cycle(11'h400, 1'b0, 1'b0, 1'b1, 1'b0, -1,  -1,  6,  -1, 6, 1'b1);
    bus_cycle(11'h009, 1'b0, 1'b0, 1'b1, 1'b0, -1,  -1,  70, -1, 6, 1'b1);
    bus_cycle(11'h009, 1'b1, 1'b0, 1'b1, 1'b0, 10,  -1,  16, -1, 6, 1'b1);
    bus_cycle(11'h000, 1'b0, 1'b0, 1'b1, 1'b1, -1,  -1,  70, -1, 6, 1'b1);
    bus_cycle(11'h000, 1'b0, 1'b0, 1'b1, 1'b1, -1,  5,   12, -1, 6, 1'b1);
    bus_cycle(11'h007, 1'b0, 1'b0, 1'b0, 1'b0, -1,  -1,  6,  -1, 6, 1'b1);
    bus_cycle(11'h001, 1'b1, 1'b0, 1'b1, 1'b0, -1,  -1,  10, -1, 6, 1'b1);
    bus_cycle(11'h002, 1'b0, 1'b0, 1'b1, 1'b0, -1,  -1,  6,  -1, 6, 1'b1);
    bus_cycle(11'h00F, 1'b0, 1'b0, 1'b0, 1'b0, 0,   -1,  8,  -1, 6, 1'b1);
    bus_cycle(11'h010, 1'b0, 1'b0, 1'b1, 1'b0, -1,  -1,  6,  -1, 6, 1'b1);
    bus_cycle(11'h7FF, 1'b0, 1'b0, 1'b1, 1'b0, -1,  -1,  6,  -1, 6, 1'b1);
    bus_cycle(11'h000, 1'b0, 1'b0, 1'b1, 1'b0, -1,  -1,  4,  -1, 6, 1'b0);
    bus_cycle(11'h004, 1'b0, 1'b0, 1'b1, 1'b0, -1,  -1,  5,  -1, 1, 1'b1);
    bus_cycle(11'h000, 1'b0, 1'b0, 1'b1, 1'b0, -1,  -1,  10, -1, 6, 1'b1);
    bus_cycle(11'h000, 1'b0, 1'b0, 1'b1, 1'b0, -1,  -1,  12, 4,  6, 1'b0);
    bus_cycle(11'h003, 1'b0, 1'b0, 1'b1, 1'b0, -1,  -1,  6,  -1, 6, 1'b1);

    chk("pins_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
